// File: rtl/conv_acc_pkg.sv
// Shared definitions for the convolution accumulator sequencer and its accumulator:
// FSM state codes and the batch_type codes carried on the accumulator interface.
package conv_acc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [1:0] BT_FIRST = 2'd0;
    localparam logic [1:0] BT_MID   = 2'd1;
    localparam logic [1:0] BT_LAST  = 2'd2;

    typedef logic [1:0] batch_type_t;

    // The first batch seeds the accumulator FIFO and the last batch releases the final sum.
    function automatic batch_type_t batch_type_of(input logic [7:0] idx, input logic [7:0] num);
        if (idx == 8'd0)
            return BT_FIRST;
        else if (idx == num - 8'd1)
            return BT_LAST;
        else
            return BT_MID;
    endfunction

endpackage

// File: rtl/conv_batch_cnt.sv
// Pixel/batch counter pair: the pixel index wraps every pix_num_i beats and bumps the batch index.
module conv_batch_cnt #(
    parameter int PIX_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [PIX_W-1:0] pix_num_i,
    output logic [7:0]       batch_o,
    output logic             wrap_o
);

    logic [PIX_W-1:0] pix_q;
    logic [7:0]       batch_q;

    assign wrap_o  = inc_i && (pix_q == pix_num_i - PIX_W'(1));
    assign batch_o = batch_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q   <= '0;
            batch_q <= '0;
        end else if (clr_i) begin
            pix_q   <= '0;
            batch_q <= '0;
        end else if (inc_i) begin
            if (wrap_o) begin
                pix_q   <= '0;
                batch_q <= batch_q + 8'd1;
            end else begin
                pix_q   <= pix_q + PIX_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_acc_batch_seq.sv
// Sequences channel batches of partial sums into the accumulator, inserting bubbles at
// batch boundaries so the accumulator FIFO write lands before the next batch reads it.
module conv_acc_batch_seq
    import conv_acc_pkg::*;
#(
    parameter int DW      = 24,
    parameter int PIX_W   = 13,
    parameter int MAX_PIX = 4096,
    parameter int GAP_CYC = 4
) (
    input  logic                 sclk,
    input  logic                 s_rst_n,
    input  logic                 start,
    input  logic [PIX_W-1:0]     cfg_pix_num,
    input  logic [7:0]           cfg_batch_num,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_vld,
    output logic                 s_rdy,
    output logic signed [DW-1:0] acc_data_in,
    output logic                 acc_data_in_vld,
    output logic [1:0]           acc_batch_type,
    output logic                 acc_out_vld,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic [1:0]           state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [PIX_W-1:0]     pix_num_q;
    logic [7:0]           batch_num_q;
    logic signed [DW-1:0] data_q;
    logic                 vld_q;
    batch_type_t          type_q;
    logic                 out_vld_q;
    logic                 done_q;
    logic                 err_q;

    logic       cfg_ok;
    logic       launch;
    logic       accept;
    logic       wrap;
    logic [7:0] batch_cnt;
    logic       last_batch;

    assign cfg_ok = (cfg_pix_num != '0) && (32'(cfg_pix_num) <= MAX_PIX) && (cfg_batch_num >= 8'd2);
    assign launch = (state_q == ST_IDLE) && start && cfg_ok;
    assign s_rdy  = (state_q == ST_RUN);
    assign accept = s_rdy && s_vld;
    assign last_batch = (batch_cnt == batch_num_q - 8'd1);

    conv_batch_cnt #(.PIX_W(PIX_W)) u_cnt (
        .clk_i     (sclk),
        .rst_ni    (s_rst_n),
        .clr_i     (launch),
        .inc_i     (accept),
        .pix_num_i (pix_num_q),
        .batch_o   (batch_cnt),
        .wrap_o    (wrap)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE:  if (launch) state_d = ST_RUN;
            ST_RUN: begin
                if (wrap) begin
                    state_d = last_batch ? ST_FLUSH : ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(GAP_CYC - 1))
                    state_d = ST_RUN;
                else
                    gap_d = gap_q + GW'(1);
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // batch_type holds across stalls within a job and is parked at FIRST once the job drains.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            pix_num_q   <= '0;
            batch_num_q <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            type_q      <= BT_FIRST;
            out_vld_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            vld_q     <= accept;
            out_vld_q <= vld_q && (type_q == BT_LAST);
            done_q    <= (state_q == ST_FLUSH);
            err_q     <= (state_q == ST_IDLE) && start && !cfg_ok;
            if (launch) begin
                pix_num_q   <= cfg_pix_num;
                batch_num_q <= cfg_batch_num;
            end
            if (accept) begin
                data_q <= s_data;
                type_q <= batch_type_of(batch_cnt, batch_num_q);
            end else if (state_q == ST_FLUSH) begin
                type_q <= BT_FIRST;
            end
        end
    end

    assign acc_data_in     = data_q;
    assign acc_data_in_vld = vld_q;
    assign acc_batch_type  = type_q;
    assign acc_out_vld     = out_vld_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign cfg_err         = err_q;

endmodule
